// File: rtl/xm23_regfile_wb.sv
// XM23 writeback register and two-bank general-purpose register file (gprc).
// Optional macro XM23_WB_BYPASS_EN forwards the pending writeback into gprc bank 0.
module xm23_regfile_wb #(
  parameter int                 DATA_W   = 16,
  parameter logic [DATA_W-1:0]  PC_RESET = '0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ex_valid,
  input  logic [2:0]                    ex_dst,
  input  logic [DATA_W-1:0]             ex_result,
  input  logic                          ex_byte,
  input  logic                          stall,
  input  logic                          pc_wr,
  input  logic [DATA_W-1:0]             pc_next,
  output logic [1:0][7:0][DATA_W-1:0]   gprc,
  output logic                          wb_busy,
  output logic [7:0]                    pend_mask
);

  localparam logic [7:0][DATA_W-1:0] CONSTS = {
    DATA_W'(16'hFFFF), DATA_W'(32), DATA_W'(16), DATA_W'(8),
    DATA_W'(4),        DATA_W'(2),  DATA_W'(1),  DATA_W'(0)
  };

  logic [7:0][DATA_W-1:0] regs_q, regs_d;
  logic                   wb_valid_q, wb_valid_d;
  logic [2:0]             wb_dst_q, wb_dst_d;
  logic [DATA_W-1:0]      wb_data_q, wb_data_d;
  logic                   wb_byte_q, wb_byte_d;

  logic                   commit;
  logic [DATA_W-1:0]      merged;

  assign commit = wb_valid_q & ~stall;
  assign merged = wb_byte_q ? {regs_q[wb_dst_q][DATA_W-1:8], wb_data_q[7:0]} : wb_data_q;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    regs_d     = regs_q;
    wb_valid_d = wb_valid_q;
    wb_dst_d   = wb_dst_q;
    wb_data_d  = wb_data_q;
    wb_byte_d  = wb_byte_q;

    if (pc_wr) regs_d[7] = pc_next;
    // Commit is applied after the PC update so a same-edge commit to R7 wins.
    if (commit) regs_d[wb_dst_q] = merged;

    if (!stall) begin
      wb_valid_d = ex_valid;
      wb_dst_d   = ex_dst;
      wb_data_d  = ex_result;
      wb_byte_d  = ex_byte;
    end
  end

  // NOTE: the register file is small and architecturally visible, so each entry has a real reset value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q     <= '0;
      regs_q[7]  <= PC_RESET;
      wb_valid_q <= 1'b0;
      wb_dst_q   <= '0;
      wb_data_q  <= '0;
      wb_byte_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all state updates see pre-edge values.
      regs_q     <= regs_d;
      wb_valid_q <= wb_valid_d;
      wb_dst_q   <= wb_dst_d;
      wb_data_q  <= wb_data_d;
      wb_byte_q  <= wb_byte_d;
    end
  end

  always_comb begin
    gprc[1] = CONSTS;
    for (int i = 0; i < 8; i++) begin
      gprc[0][i] = regs_q[i];
`ifdef XM23_WB_BYPASS_EN
      if (wb_valid_q && (wb_dst_q == 3'(i))) gprc[0][i] = merged;
`endif
    end
  end

  assign wb_busy   = wb_valid_q;
  assign pend_mask = wb_valid_q ? (8'b1 << wb_dst_q) : 8'h00;

endmodule
